// File: rtl/draw_pkg.sv
// draw_pkg: shared screen defaults, draw modes and FSM encoding for the rectangle drawers
package draw_pkg;
  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;
  localparam logic MODE_FILL = 1'b0;
  localparam logic MODE_OUTLINE = 1'b1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/rect_scan_counter.sv
// rect_scan_counter: row-major cx/cy scan over a w x h box with advance enable and border/last flags
module rect_scan_counter #(
  parameter int SIZE_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              adv,
  input  logic [SIZE_W-1:0] w,
  input  logic [SIZE_W-1:0] h,
  output logic [SIZE_W-1:0] cx,
  output logic [SIZE_W-1:0] cy,
  output logic              row_end,
  output logic              last,
  output logic              border
);
  localparam logic [SIZE_W-1:0] ONE = {{(SIZE_W-1){1'b0}}, 1'b1};
  logic col_last;
  always_comb begin
    row_end = cx == w - ONE;
    col_last = cy == h - ONE;
    last = row_end && col_last;
    border = cx == '0 || row_end || cy == '0 || col_last;
  end
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cx <= '0;
      cy <= '0;
    end else if (adv) begin
      cx <= row_end ? '0 : cx + ONE;
      cy <= row_end ? cy + ONE : cy;
    end
  end
endmodule

// File: rtl/draw_rect_engine.sv
// draw_rect_engine: rectangle rasteriser with start/busy/done, backpressure, fill/outline and clipping
module draw_rect_engine
  import draw_pkg::*;
#(
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int SIZE_W = 5,
  parameter int COLOR_W = 3,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [X_W-1:0]     x_in,
  input  logic [Y_W-1:0]     y_in,
  input  logic [SIZE_W-1:0]  width,
  input  logic [SIZE_W-1:0]  height,
  input  logic [COLOR_W-1:0] c_in,
  input  logic               mode,
  input  logic               plot_ready,
  output logic [X_W-1:0]     x_out,
  output logic [Y_W-1:0]     y_out,
  output logic [COLOR_W-1:0] c_out,
  output logic               plot,
  output logic               busy,
  output logic               done
);
  localparam logic [X_W:0] XLIM = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] YLIM = (Y_W+1)'(SCREEN_H);
  localparam logic [X_W:0] X1 = {{X_W{1'b0}}, 1'b1};
  localparam logic [Y_W:0] Y1 = {{Y_W{1'b0}}, 1'b1};
  state_t state;
  logic [X_W:0] xs;
  logic [Y_W:0] ys;
  logic [X_W-1:0] x0;
  logic [Y_W-1:0] y0;
  logic [SIZE_W-1:0] rect_w, rect_h, cx, cy;
  logic md, row_end, last, border, vis, adv, load;
  // xs/ys carry the extra sum bit so a wrapped coordinate is seen as off-screen
  assign x_out = xs[X_W-1:0];
  assign y_out = ys[Y_W-1:0];
  always_comb begin
    vis = xs < XLIM && ys < YLIM;
    plot = state == RUN && vis && (md == MODE_FILL || border);
    adv = state == RUN && (!plot || plot_ready);
    load = state == IDLE && start && width != '0 && height != '0;
  end
  rect_scan_counter #(.SIZE_W(SIZE_W)) scan (
    .clk(clk),
    .reset(reset),
    .clr(load),
    .adv(adv),
    .w(rect_w),
    .h(rect_h),
    .cx(cx),
    .cy(cy),
    .row_end(row_end),
    .last(last),
    .border(border)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      xs <= '0;
      ys <= '0;
      c_out <= '0;
      x0 <= '0;
      y0 <= '0;
      rect_w <= '0;
      rect_h <= '0;
      md <= MODE_FILL;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= load ? RUN : DONE;
            busy <= 1'b1;
            done <= !load;
          end
          if (load) begin
            x0 <= x_in;
            y0 <= y_in;
            rect_w <= width;
            rect_h <= height;
            md <= mode;
            c_out <= c_in;
            xs <= {1'b0, x_in};
            ys <= {1'b0, y_in};
          end
        end
        RUN: begin
          if (adv && last) begin
            state <= DONE;
            done <= 1'b1;
          end else if (adv) begin
            xs <= row_end ? {1'b0, x0} : {1'b0, x0} + (X_W+1)'(cx) + X1;
            ys <= row_end ? {1'b0, y0} + (Y_W+1)'(cy) + Y1 : ys;
          end
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase
    end
  end
endmodule
